// File: rtl/snitch_tcdm_resp_pkg.sv
// Shared types for the TCDM bank responder: FSM states, AMO encoding and request/response structs.
package snitch_tcdm_resp_pkg;

    localparam int unsigned LaneWidth = 32;
    localparam int unsigned UserWidth = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        AMO_WB = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        AMONone = 4'd0,
        AMOSwap = 4'd1,
        AMOAdd  = 4'd2,
        AMOAnd  = 4'd3,
        AMOOr   = 4'd4,
        AMOXor  = 4'd5,
        AMOMax  = 4'd6,
        AMOMaxu = 4'd7,
        AMOMin  = 4'd8,
        AMOMinu = 4'd9,
        AMOLR   = 4'd10,
        AMOSC   = 4'd11
    } amo_op_e;

    // Default channel flavours for 32-bit and 64-bit banks.
    typedef struct packed {
        logic [31:0]          addr;
        logic                 write;
        amo_op_e              amo;
        logic [31:0]          data;
        logic [3:0]           strb;
        logic [UserWidth-1:0] user;
    } tcdm_req_chan_d32_t;

    typedef struct packed {
        logic               q_valid;
        tcdm_req_chan_d32_t q;
    } tcdm_req_d32_t;

    typedef struct packed {
        logic [31:0] data;
    } tcdm_rsp_chan_d32_t;

    typedef struct packed {
        logic               q_ready;
        logic               p_valid;
        tcdm_rsp_chan_d32_t p;
    } tcdm_rsp_d32_t;

    typedef struct packed {
        logic [31:0]          addr;
        logic                 write;
        amo_op_e              amo;
        logic [63:0]          data;
        logic [7:0]           strb;
        logic [UserWidth-1:0] user;
    } tcdm_req_chan_d64_t;

    typedef struct packed {
        logic               q_valid;
        tcdm_req_chan_d64_t q;
    } tcdm_req_d64_t;

    typedef struct packed {
        logic [63:0] data;
    } tcdm_rsp_chan_d64_t;

    typedef struct packed {
        logic               q_ready;
        logic               p_valid;
        tcdm_rsp_chan_d64_t p;
    } tcdm_rsp_d64_t;

endpackage

// File: rtl/snitch_amo_alu.sv
// Combinational 32-bit atomic ALU: computes the value written back for an AMO.
module snitch_amo_alu
    import snitch_tcdm_resp_pkg::*;
(
    input  amo_op_e              amo_op_i,
    input  logic [LaneWidth-1:0] old_i,
    input  logic [LaneWidth-1:0] operand_i,
    output logic [LaneWidth-1:0] result_o
);

    always_comb begin
        result_o = operand_i;
        case (amo_op_i)
            AMOSwap: result_o = operand_i;
            AMOAdd:  result_o = old_i + operand_i;
            AMOAnd:  result_o = old_i & operand_i;
            AMOOr:   result_o = old_i | operand_i;
            AMOXor:  result_o = old_i ^ operand_i;
            AMOMax:  result_o = ($signed(old_i) > $signed(operand_i)) ? old_i : operand_i;
            AMOMaxu: result_o = (old_i > operand_i) ? old_i : operand_i;
            AMOMin:  result_o = ($signed(old_i) < $signed(operand_i)) ? old_i : operand_i;
            AMOMinu: result_o = (old_i < operand_i) ? old_i : operand_i;
            default: result_o = operand_i;
        endcase
    end

endmodule

// File: rtl/snitch_tcdm_bank_responder.sv
// TCDM agent endpoint driving one 1-cycle-latency SRAM bank, with in-place AMO read-modify-write.
// Optional LR/SC reservation tracking is enabled by defining SNITCH_TCDM_RESPONDER_LRSC_EN.
module snitch_tcdm_bank_responder
    import snitch_tcdm_resp_pkg::*;
#(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned MemAddrWidth = 10,
    parameter type         tcdm_req_t   = tcdm_req_d32_t,
    parameter type         tcdm_rsp_t   = tcdm_rsp_d32_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  tcdm_req_t              tcdm_req_i,
    output tcdm_rsp_t              tcdm_rsp_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    localparam int unsigned ByteOffset = $clog2(DataWidth/8);
    localparam int unsigned StrbWidth  = DataWidth/8;
    localparam int unsigned NumLanes   = DataWidth/LaneWidth;

    state_e                  state_q, state_d;
    logic                    p_valid_q, p_valid_d;
    logic [MemAddrWidth-1:0] addr_q, addr_d;
    logic [LaneWidth-1:0]    operand_q, operand_d;
    logic                    lane_q, lane_d;
    amo_op_e                 op_q, op_d;
    logic                    sc_rsp_q, sc_rsp_d;
    logic                    sc_fail_q, sc_fail_d;

    logic [MemAddrWidth-1:0] req_addr;
    logic                    req_lane;
    logic [LaneWidth-1:0]    req_lane_data, old_lane, alu_result;
    logic [StrbWidth-1:0]    amo_be;
    logic                    q_ready;

`ifdef SNITCH_TCDM_RESPONDER_LRSC_EN
    logic                    resv_valid_q, resv_valid_d;
    logic [MemAddrWidth-1:0] resv_addr_q, resv_addr_d;
    logic [UserWidth-1:0]    resv_user_q, resv_user_d;
`endif

    assign req_addr = tcdm_req_i.q.addr[ByteOffset +: MemAddrWidth];

    // On wide banks only one 32-bit lane takes part in an AMO; the other lane is masked off.
    if (NumLanes > 1) begin : g_wide
        assign req_lane      = tcdm_req_i.q.addr[2];
        assign req_lane_data = req_lane ? tcdm_req_i.q.data[2*LaneWidth-1:LaneWidth]
                                        : tcdm_req_i.q.data[LaneWidth-1:0];
        assign old_lane      = lane_q ? mem_rdata_i[2*LaneWidth-1:LaneWidth]
                                      : mem_rdata_i[LaneWidth-1:0];
        assign amo_be        = lane_q ? {{(StrbWidth/2){1'b1}}, {(StrbWidth/2){1'b0}}}
                                      : {{(StrbWidth/2){1'b0}}, {(StrbWidth/2){1'b1}}};
    end else begin : g_narrow
        assign req_lane      = 1'b0;
        assign req_lane_data = tcdm_req_i.q.data[LaneWidth-1:0];
        assign old_lane      = mem_rdata_i[LaneWidth-1:0];
        assign amo_be        = '1;
    end

    snitch_amo_alu u_alu (
        .amo_op_i  (op_q),
        .old_i     (old_lane),
        .operand_i (operand_q),
        .result_o  (alu_result)
    );

    always_comb begin
        state_d     = state_q;
        p_valid_d   = 1'b0;
        addr_d      = addr_q;
        operand_d   = operand_q;
        lane_d      = lane_q;
        op_d        = op_q;
        sc_rsp_d    = 1'b0;
        sc_fail_d   = 1'b0;
        q_ready     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = req_addr;
        mem_wdata_o = tcdm_req_i.q.data;
        mem_be_o    = tcdm_req_i.q.strb;
`ifdef SNITCH_TCDM_RESPONDER_LRSC_EN
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        resv_user_d  = resv_user_q;
`endif
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    q_ready = 1'b1;
                    if (tcdm_req_i.q_valid) begin
                        mem_req_o = 1'b1;
                        p_valid_d = 1'b1;
                        case (tcdm_req_i.q.amo)
                            AMONone: mem_we_o = tcdm_req_i.q.write;
                            AMOLR: begin
`ifdef SNITCH_TCDM_RESPONDER_LRSC_EN
                                resv_valid_d = 1'b1;
                                resv_addr_d  = req_addr;
                                resv_user_d  = tcdm_req_i.q.user;
`endif
                            end
                            AMOSC: begin
                                sc_rsp_d = 1'b1;
`ifdef SNITCH_TCDM_RESPONDER_LRSC_EN
                                if (resv_valid_q && (resv_addr_q == req_addr)
                                    && (resv_user_q == tcdm_req_i.q.user)) begin
                                    mem_we_o     = 1'b1;
                                    resv_valid_d = 1'b0;
                                end else begin
                                    sc_fail_d = 1'b1;
                                end
`else
                                mem_we_o = 1'b1;
`endif
                            end
                            default: begin
                                addr_d    = req_addr;
                                operand_d = req_lane_data;
                                lane_d    = req_lane;
                                op_d      = tcdm_req_i.q.amo;
                                state_d   = AMO_WB;
                            end
                        endcase
`ifdef SNITCH_TCDM_RESPONDER_LRSC_EN
                        if (mem_we_o && (req_addr == resv_addr_q)) resv_valid_d = 1'b0;
`endif
                    end
                end
                AMO_WB: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = addr_q;
                    mem_wdata_o = {NumLanes{alu_result}};
                    mem_be_o    = amo_be;
                    state_d     = IDLE;
`ifdef SNITCH_TCDM_RESPONDER_LRSC_EN
                    if (addr_q == resv_addr_q) resv_valid_d = 1'b0;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The response is gated by reset so an in-flight AMO reply is dropped immediately.
    always_comb begin
        tcdm_rsp_o         = '0;
        tcdm_rsp_o.q_ready = q_ready;
        tcdm_rsp_o.p_valid = p_valid_q & ~rst_i;
        tcdm_rsp_o.p.data  = sc_rsp_q ? DataWidth'(sc_fail_q) : mem_rdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            p_valid_q <= 1'b0;
            addr_q    <= '0;
            operand_q <= '0;
            lane_q    <= 1'b0;
            op_q      <= AMONone;
            sc_rsp_q  <= 1'b0;
            sc_fail_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_valid_q <= p_valid_d;
            addr_q    <= addr_d;
            operand_q <= operand_d;
            lane_q    <= lane_d;
            op_q      <= op_d;
            sc_rsp_q  <= sc_rsp_d;
            sc_fail_q <= sc_fail_d;
        end
    end

`ifdef SNITCH_TCDM_RESPONDER_LRSC_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            resv_user_q  <= '0;
        end else begin
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
            resv_user_q  <= resv_user_d;
        end
    end
`endif

endmodule

// File: tb/tb_snitch_tcdm_bank_responder.sv
// Directed bench for snitch_tcdm_bank_responder with 32-bit and 64-bit banks and behavioural SRAMs.
module tb_snitch_tcdm_bank_responder;
    import snitch_tcdm_resp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tcdm_req_d32_t req32;
    tcdm_rsp_d32_t rsp32;
    logic          mreq32, mwe32;
    logic [9:0]    maddr32;
    logic [31:0]   mwdata32, mrdata32;
    logic [3:0]    mbe32;

    tcdm_req_d64_t req64;
    tcdm_rsp_d64_t rsp64;
    logic          mreq64, mwe64;
    logic [9:0]    maddr64;
    logic [63:0]   mwdata64, mrdata64;
    logic [7:0]    mbe64;

    snitch_tcdm_bank_responder #(
        .AddrWidth(32), .DataWidth(32), .MemAddrWidth(10),
        .tcdm_req_t(tcdm_req_d32_t), .tcdm_rsp_t(tcdm_rsp_d32_t)
    ) dut32 (
        .clk_i(clk), .rst_i(rst), .tcdm_req_i(req32), .tcdm_rsp_o(rsp32),
        .mem_req_o(mreq32), .mem_we_o(mwe32), .mem_addr_o(maddr32),
        .mem_wdata_o(mwdata32), .mem_be_o(mbe32), .mem_rdata_i(mrdata32)
    );

    snitch_tcdm_bank_responder #(
        .AddrWidth(32), .DataWidth(64), .MemAddrWidth(10),
        .tcdm_req_t(tcdm_req_d64_t), .tcdm_rsp_t(tcdm_rsp_d64_t)
    ) dut64 (
        .clk_i(clk), .rst_i(rst), .tcdm_req_i(req64), .tcdm_rsp_o(rsp64),
        .mem_req_o(mreq64), .mem_we_o(mwe64), .mem_addr_o(maddr64),
        .mem_wdata_o(mwdata64), .mem_be_o(mbe64), .mem_rdata_i(mrdata64)
    );

    logic [31:0] mem32 [1024];
    logic [63:0] mem64 [1024];

    always @(posedge clk) begin
        if (mreq32) begin
            if (mwe32) begin
                for (int b = 0; b < 4; b++)
                    if (mbe32[b]) mem32[maddr32][8*b +: 8] <= mwdata32[8*b +: 8];
            end else begin
                mrdata32 <= mem32[maddr32];
            end
        end
    end

    always @(posedge clk) begin
        if (mreq64) begin
            if (mwe64) begin
                for (int b = 0; b < 8; b++)
                    if (mbe64[b]) mem64[maddr64][8*b +: 8] <= mwdata64[8*b +: 8];
            end else begin
                mrdata64 <= mem64[maddr64];
            end
        end
    end

    typedef struct {
        bit          w64;
        logic [63:0] data;
        bit          care;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        amo_op_e     op;
        logic [31:0] old;
        logic [31:0] opnd;
        logic [31:0] res;
    } amo_vec_t;

    amo_vec_t tbl [9] = '{
        '{AMOSwap, 32'h000000F0, 32'hFFFFFF0F, 32'hFFFFFF0F},
        '{AMOAdd,  32'hFFFFFFFF, 32'h00000002, 32'h00000001},
        '{AMOAnd,  32'h000000F0, 32'hFFFFFF0F, 32'h00000000},
        '{AMOOr,   32'h000000F0, 32'hFFFFFF0F, 32'hFFFFFFFF},
        '{AMOXor,  32'h0F0F0F0F, 32'hFF00FF00, 32'hF00FF00F},
        '{AMOMin,  32'h000000F0, 32'hFFFFFF0F, 32'hFFFFFF0F},
        '{AMOMinu, 32'h000000F0, 32'hFFFFFF0F, 32'h000000F0},
        '{AMOMax,  32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF},
        '{AMOMaxu, 32'h80000000, 32'h7FFFFFFF, 32'h80000000}
    };

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every handshake must produce exactly one response in the following cycle.
    task automatic check_rsp();
        sb_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.w64 ? "p_valid64" : "p_valid32", e.w64 ? rsp64.p_valid : rsp32.p_valid, 1'b1);
            chk(e.w64 ? "other_p_valid32" : "other_p_valid64", e.w64 ? rsp32.p_valid : rsp64.p_valid, 1'b0);
            if (e.care)
                chk("p_data", e.w64 ? rsp64.p.data : {32'b0, rsp32.p.data}, e.data);
        end else begin
            chk("idle_p_valid32", rsp32.p_valid, 1'b0);
            chk("idle_p_valid64", rsp64.p_valid, 1'b0);
        end
    endtask

    task automatic step(input bit w64, input bit v, input logic [31:0] addr, input bit wr,
                        input amo_op_e amo, input logic [63:0] data, input logic [7:0] strb,
                        input logic [3:0] user, input bit exp_rdy, input logic [63:0] exp_data,
                        input bit care);
        logic rdy;
        @(negedge clk);
        req32 = '0;
        req64 = '0;
        if (w64) begin
            req64.q_valid = v;  req64.q.addr = addr; req64.q.write = wr; req64.q.amo = amo;
            req64.q.data = data; req64.q.strb = strb; req64.q.user = user;
        end else begin
            req32.q_valid = v;  req32.q.addr = addr; req32.q.write = wr; req32.q.amo = amo;
            req32.q.data = data[31:0]; req32.q.strb = strb[3:0]; req32.q.user = user;
        end
        #1;
        check_rsp();
        rdy = w64 ? rsp64.q_ready : rsp32.q_ready;
        chk(w64 ? "q_ready64" : "q_ready32", rdy, exp_rdy);
        if (v && rdy) sb.push_back('{w64, exp_data, care});
        @(posedge clk);
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        step(0, 1, a, 1, AMONone, {32'b0, d}, 8'h0F, 4'd0, 1, 64'd0, 0);
    endtask

    task automatic rd32(input logic [31:0] a, input logic [31:0] exp);
        step(0, 1, a, 0, AMONone, 64'd0, 8'h00, 4'd0, 1, {32'b0, exp}, 1);
    endtask

    task automatic amo32(input amo_op_e op, input logic [31:0] a, input logic [31:0] opnd,
                         input logic [31:0] exp_old);
        step(0, 1, a, 0, op, {32'b0, opnd}, 8'h0F, 4'd0, 1, {32'b0, exp_old}, 1);
    endtask

    task automatic idle(input bit w64, input bit exp_rdy);
        step(w64, 0, 32'd0, 0, AMONone, 64'd0, 8'h00, 4'd0, exp_rdy, 64'd0, 0);
    endtask

    initial begin
        rst   = 1'b1;
        req32 = '0;
        req64 = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_q_ready32", rsp32.q_ready, 1'b0);
        chk("rst_p_valid32", rsp32.p_valid, 1'b0);
        chk("rst_mem_req32", mreq32, 1'b0);
        chk("rst_mem_we32", mwe32, 1'b0);
        chk("rst_q_ready64", rsp64.q_ready, 1'b0);
        chk("rst_mem_req64", mreq64, 1'b0);
        rst = 1'b0;

        // Write then read back
        wr32(32'h40, 32'hDEADBEEF);
        rd32(32'h40, 32'hDEADBEEF);
        idle(0, 1);

        // Back-to-back reads with no bubble
        wr32(32'h0, 32'd0);
        wr32(32'h4, 32'd1);
        wr32(32'h8, 32'd2);
        rd32(32'h0, 32'd0);
        rd32(32'h4, 32'd1);
        rd32(32'h8, 32'd2);
        idle(0, 1);

        // AMO add: a read pending during write-back is accepted one cycle later
        wr32(32'h80, 32'd10);
        amo32(AMOAdd, 32'h80, 32'd5, 32'd10);
        step(0, 1, 32'h80, 0, AMONone, 64'd0, 8'h00, 4'd0, 0, 64'd0, 0);
        rd32(32'h80, 32'd15);
        idle(0, 1);

        // Signed vs unsigned max
        wr32(32'h84, 32'd3);
        amo32(AMOMax, 32'h84, 32'hFFFFFFFF, 32'd3);
        idle(0, 0);
        rd32(32'h84, 32'd3);
        wr32(32'h88, 32'd3);
        amo32(AMOMaxu, 32'h88, 32'hFFFFFFFF, 32'd3);
        idle(0, 0);
        rd32(32'h88, 32'hFFFFFFFF);
        idle(0, 1);

        for (int i = 0; i < 9; i++) begin
            wr32(32'h100 + 4*i, tbl[i].old);
            amo32(tbl[i].op, 32'h100 + 4*i, tbl[i].opnd, tbl[i].old);
            idle(0, 0);
            rd32(32'h100 + 4*i, tbl[i].res);
        end
        idle(0, 1);

        // Back-to-back AMOs: second one stalls one cycle
        wr32(32'h200, 32'd1);
        amo32(AMOAdd, 32'h200, 32'd1, 32'd1);
        step(0, 1, 32'h200, 0, AMOAdd, 64'd1, 8'h0F, 4'd0, 0, 64'd0, 0);
        amo32(AMOAdd, 32'h200, 32'd1, 32'd2);
        idle(0, 0);
        rd32(32'h200, 32'd3);
        idle(0, 1);

`ifdef SNITCH_TCDM_RESPONDER_LRSC_EN
        step(0, 1, 32'h80, 0, AMOLR, 64'd0, 8'h00, 4'd1, 1, 64'd15, 1);
        step(0, 1, 32'h80, 0, AMOSC, 64'h99, 8'h0F, 4'd1, 1, 64'd0, 1);
        rd32(32'h80, 32'h99);
        step(0, 1, 32'h80, 0, AMOLR, 64'd0, 8'h00, 4'd1, 1, 64'h99, 1);
        step(0, 1, 32'h80, 1, AMONone, 64'h77, 8'h0F, 4'd2, 1, 64'd0, 0);
        step(0, 1, 32'h80, 0, AMOSC, 64'h66, 8'h0F, 4'd1, 1, 64'd1, 1);
        rd32(32'h80, 32'h77);
        idle(0, 1);
`else
        step(0, 1, 32'h90, 0, AMOSC, 64'h55, 8'h0F, 4'd1, 1, 64'd0, 1);
        step(0, 1, 32'h90, 0, AMOLR, 64'd0, 8'h00, 4'd1, 1, 64'h55, 1);
        idle(0, 1);
`endif

        // 64-bit bank: AMOs touch only the addressed 32-bit lane
        step(1, 1, 32'h100, 1, AMONone, 64'hAAAAAAAA_BBBBBBBB, 8'hFF, 4'd0, 1, 64'd0, 0);
        step(1, 1, 32'h104, 0, AMOSwap, 64'h00001234_00000000, 8'hFF, 4'd0, 1,
             64'hAAAAAAAA_BBBBBBBB, 1);
        idle(1, 0);
        step(1, 1, 32'h100, 0, AMONone, 64'd0, 8'h00, 4'd0, 1, 64'h00001234_BBBBBBBB, 1);
        step(1, 1, 32'h100, 0, AMOAdd, 64'h00000000_00000001, 8'hFF, 4'd0, 1,
             64'h00001234_BBBBBBBB, 1);
        idle(1, 0);
        step(1, 1, 32'h100, 0, AMONone, 64'd0, 8'h00, 4'd0, 1, 64'h00001234_BBBBBBBC, 1);
        idle(1, 1);

        // Reset during write-back aborts it
        wr32(32'hC0, 32'd7);
        amo32(AMOAdd, 32'hC0, 32'd1, 32'd7);
        @(negedge clk);
        req32 = '0;
        rst   = 1'b1;
        #1;
        chk("rst_wb_p_valid", rsp32.p_valid, 1'b0);
        chk("rst_wb_q_ready", rsp32.q_ready, 1'b0);
        chk("rst_wb_mem_req", mreq32, 1'b0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_q_ready", rsp32.q_ready, 1'b1);
        @(posedge clk);
        rd32(32'hC0, 32'd7);
        idle(0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
